johnson_counter_param: RTL and testbench

Parametrised N-bit Johnson (twisted-ring) counter. This is the successor to the fixed 8-bit counter. It adds count enable, up/down direction, and synchronous load. It also adds illegal-state detection with self-recovery, binary phase decode, and a wrap pulse. It is used as a 2N-phase sequencer and clock-phase generator in control datapaths.

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_decode.sv | 14 +
 rtl/johnson_counter_param.sv | 45 ++++
 tb/tb_johnson_counter_param.sv | 128 ++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared legality and phase-decode helpers for Johnson counters up to 32 bits
package johnson_pkg;
  localparam int JC_MAX_W = 32;
  localparam int JC_PH_MAX_W = $clog2(2 * JC_MAX_W);
  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] c, input int w);
    int t;
    t = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) if (i < w - 1 && c[i] != c[i+1]) t++;
    return t <= 1;
  endfunction
  // Legal states with bit 0 set are the fill half (phase = ones); otherwise the drain half.
  function automatic logic [JC_PH_MAX_W-1:0] jc_phase(input logic [JC_MAX_W-1:0] c, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_MAX_W; i++) ones += int'(c[i]);
    return (!jc_legal(c, w) || ones == 0) ? '0 :
           c[0] ? JC_PH_MAX_W'(ones) : JC_PH_MAX_W'(2 * w - ones);
  endfunction
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational phase index and legality of a Johnson state
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]            count,
  output logic [$clog2(2*WIDTH)-1:0] phase,
  output logic                        legal
);
  localparam int PH_W = $clog2(2 * WIDTH);
  assign legal = jc_legal(JC_MAX_W'(count), WIDTH);
  assign phase = PH_W'(jc_phase(JC_MAX_W'(count), WIDTH));
endmodule

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: N-bit up/down Johnson counter with load, self-recovery, phase decode and wrap
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        dir,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_val,
  output logic [WIDTH-1:0]            count,
  output logic [$clog2(2*WIDTH)-1:0] phase,
  output logic                        wrap,
  output logic                        err
);
  localparam int PH_W = $clog2(2 * WIDTH);
  localparam logic [PH_W-1:0] LAST = PH_W'(2 * WIDTH - 1);
  logic [WIDTH-1:0] count_q, count_d, up_val, dn_val;
  logic             wrap_q, wrap_d, err_q, err_d, legal, ld_ok;
  johnson_decode #(.WIDTH(WIDTH)) u_dec (.count(count_q), .phase(phase), .legal(legal));
  assign up_val = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
  assign dn_val = {~count_q[0], count_q[WIDTH-1:1]};
  assign ld_ok  = jc_legal(JC_MAX_W'(load_val), WIDTH);
  always_comb begin
    count_d = load ? (ld_ok ? load_val : '0) : !legal ? '0 : en ? (dir ? dn_val : up_val) : count_q;
    err_d   = load ? !ld_ok : !legal;
    wrap_d  = !load && legal && en && (dir ? phase == '0 : phase == LAST);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
  assign err   = err_q;
endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param: scoreboard bench for the 8-bit and 2-bit Johnson counters
module tb_johnson_counter_param;
  typedef struct {
    logic [7:0] c;
    logic [3:0] p;
    logic       w;
    logic       e;
  } exp_t;
  logic clk = 0, reset = 1, en = 0, dir = 0, load = 0, en2 = 0, dir2 = 0, load2 = 0;
  logic [7:0] load_val = 0;
  logic [1:0] load_val2 = 0;
  logic [7:0] count;
  logic [3:0] phase;
  logic       wrap, err;
  logic [1:0] count2, phase2;
  logic       wrap2, err2;
  logic [7:0] cm = 0;
  logic [7:0] seq [17] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  exp_t sb[$];
  int checks = 0, errors = 0;
  johnson_counter_param #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(count), .phase(phase), .wrap(wrap), .err(err));
  johnson_counter_param #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .dir(dir2), .load(load2), .load_val(load_val2),
    .count(count2), .phase(phase2), .wrap(wrap2), .err(err2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pat(input int k);
    logic [15:0] one;
    one = 16'd1;
    return k <= 8 ? 8'((one << k) - 1) : ~8'((one << (k - 8)) - 1);
  endfunction
  function automatic int idx(input logic [7:0] c);
    for (int k = 0; k < 16; k++) if (pat(k) == c) return k;
    return -1;
  endfunction
  task automatic step(input logic e, input logic d, input logic l, input logic [7:0] lv);
    exp_t x;
    int   k;
    en = e; dir = d; load = l; load_val = lv;
    x.w = 0; x.e = 0;
    k = idx(cm);
    if (l) begin
      if (idx(lv) >= 0) cm = lv;
      else begin cm = 0; x.e = 1; end
    end else if (k < 0) begin
      cm = 0; x.e = 1;
    end else if (e) begin
      x.w = d ? (k == 0) : (k == 15);
      cm  = pat(d ? (k + 15) % 16 : (k + 1) % 16);
    end
    k = idx(cm);
    x.c = cm;
    x.p = k < 0 ? 4'd0 : 4'(k);
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    check("count", 32'(count), 32'(x.c));
    check("phase", 32'(phase), 32'(x.p));
    check("wrap", 32'(wrap), 32'(x.w));
    check("err", 32'(err), 32'(x.e));
    load = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count2", 32'(count2), 0);
    reset = 0;
    en2 = 1;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0);
      check("seq_up", 32'(count), 32'(seq[i+1]));
      check("seq_phase", 32'(phase), 32'((i + 1) % 16));
      check("gray_w2", 32'(count2), 32'(gray[(i+1)%4]));
      check("gray_ph_w2", 32'(phase2), 32'((i + 1) % 4));
    end
    en2 = 0;
    check("wrap_up", 32'(wrap), 1);
    step(1, 1, 0, 0);
    check("down_80", 32'(count), 32'h80);
    check("wrap_down", 32'(wrap), 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("down_e0", 32'(count), 32'hE0);
    step(0, 0, 1, 8'h1F);
    step(1, 0, 0, 0);
    check("load_step", 32'(count), 32'h3F);
    step(0, 0, 1, 8'h5A);
    step(0, 0, 0, 0);
    force dut.count_q = 8'h24;
    #1;
    check("forced_count", 32'(count), 32'h24);
    check("illegal_phase", 32'(phase), 0);
    release dut.count_q;
    cm = 8'h24;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    check("pre_rst_fe", 32'(count), 32'hFE);
    #2 reset = 1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_phase", 32'(phase), 0);
    check("arst_wrap", 32'(wrap), 0);
    check("arst_err", 32'(err), 0);
    cm = 0;
    @(negedge clk);
    reset = 0;
    step(1, 0, 0, 0);
    check("post_rst", 32'(count), 32'h01);
    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
